// File: rtl/pwm_capture_x100_if.sv
// Interface bundling the tick enable, PWM line and the recovered duty outputs of
// the x100 PWM capture block.
interface pwm_capture_x100_if #(
  parameter int CW = 7
);
  logic          ena;
  logic          pwm_in;
  logic [CW-1:0] duty;
  logic          valid;
  logic          locked;
  logic          err;

  modport master (output ena, output pwm_in,
                  input  duty, input valid, input locked, input err);
  modport slave  (input  ena, input pwm_in,
                  output duty, output valid, output locked, output err);
endinterface

// File: rtl/pwm_capture_x100.sv
// Recovers the duty (0..PERIOD) of a PWM line whose frames are PERIOD ena ticks
// long and start on a rising edge; a constant line is reported via timeout.
module pwm_capture_x100 #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD      = 100,
  parameter int CW          = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_capture_x100_if.slave  bus
);

  typedef enum logic {SYNC, MEAS} state_t;

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] FULL = CW'(PERIOD);

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, prev, rise;
  logic [CW-1:0]          win, win_n;
  logic [CW-1:0]          hcnt, hcnt_n, hcnt_sum;
  logic [CW-1:0]          tcnt, tcnt_n;
  logic [CW-1:0]          duty_q, duty_n;
  logic                   valid_q, valid_n;
  logic                   err_q, err_n;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = bus.ena & s & ~prev;

  // The synchronizer runs every clk; only the edge-detect history follows ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its source.
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
      if (bus.ena) prev <= s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SYNC;
      win     <= '0;
      hcnt    <= '0;
      tcnt    <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      win     <= win_n;
      hcnt    <= hcnt_n;
      tcnt    <= tcnt_n;
      duty_q  <= duty_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
    state_n  = state;
    win_n    = win;
    hcnt_n   = hcnt;
    tcnt_n   = tcnt;
    duty_n   = duty_q;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    hcnt_sum = hcnt + CW'(s);

    if (bus.ena) begin
      case (state)
        SYNC: begin
          if (rise) begin
            state_n = MEAS;
            win_n   = CW'(1);
            hcnt_n  = CW'(1);
            tcnt_n  = '0;
          end else if (tcnt == LAST) begin
            // A full frame without an edge: the line is constant.
            duty_n  = s ? FULL : '0;
            valid_n = 1'b1;
            tcnt_n  = '0;
          end else begin
            tcnt_n = tcnt + CW'(1);
          end
        end
        MEAS: begin
          if (win == '0) begin
            if (rise) begin
              win_n  = CW'(1);
              hcnt_n = CW'(1);
            end else begin
              state_n = SYNC;
              tcnt_n  = CW'(1);
            end
          end else if (rise) begin
            // Edge inside a frame: flag it and realign on this edge.
            err_n  = 1'b1;
            win_n  = CW'(1);
            hcnt_n = CW'(1);
          end else if (win == LAST) begin
            duty_n  = hcnt_sum;
            valid_n = 1'b1;
            win_n   = '0;
            hcnt_n  = '0;
          end else begin
            win_n  = win + CW'(1);
            hcnt_n = hcnt_sum;
          end
        end
      endcase
    end
  end

  assign bus.duty   = duty_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.locked = (state == MEAS);

endmodule
